// File: rtl/sum8_arbiter_pkg.sv
// Shared types and constants for the sum_8 adder-tree arbiter.
// Holds the FSM state encoding and the in-flight tag entry layout.
package sum8_arbiter_pkg;

    localparam int FP_W          = 32;
    localparam int BEAT_W        = 256;
    localparam int TREE_LAT_SUM8 = 4;
    localparam int TAG_ID_W      = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // Wide enough for the largest supported lane count; narrower IDs are zero-extended.
    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
        logic                last;
    } tag_t;

endpackage

// File: rtl/sum8_arbiter_if.sv
// Requester, adder-tree and response signals of the sum_8 arbiter.
// The arbiter uses the slave modport; the lanes/tree side uses master.
interface sum8_arbiter_if
    import sum8_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*BEAT_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tree_in_valid;
    logic [BEAT_W-1:0]         tree_in_data;
    logic                      tree_out_valid;
    logic [FP_W-1:0]           tree_out_data;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [FP_W-1:0]           rsp_data;
    logic                      rsp_last;
    logic                      err_tag;

    modport slave (
        input  req_valid, req_last, req_data, tree_out_valid, tree_out_data,
        output req_ready, tree_in_valid, tree_in_data,
        output rsp_valid, rsp_id, rsp_data, rsp_last, err_tag
    );

    modport master (
        output req_valid, req_last, req_data, tree_out_valid, tree_out_data,
        input  req_ready, tree_in_valid, tree_in_data,
        input  rsp_valid, rsp_id, rsp_data, rsp_last, err_tag
    );
endinterface

// File: rtl/sum8_tag_pipe.sv
// Requester-tag delay line matched to the sum_8 latency; returns each tree
// result to its issuer and flags any tag/valid disagreement (sticky).
module sum8_tag_pipe
    import sum8_arbiter_pkg::*;
#(
    parameter int TREE_LAT = TREE_LAT_SUM8,
    parameter int ID_W     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  tag_t            tag_in,
    input  logic            tree_out_valid,
    input  logic [FP_W-1:0] tree_out_data,
    output logic            rsp_valid,
    output logic [ID_W-1:0] rsp_id,
    output logic [FP_W-1:0] rsp_data,
    output logic            rsp_last,
    output logic            err_tag
);
    tag_t tag_p [TREE_LAT];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < TREE_LAT; i++) tag_p[i] <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            err_tag   <= 1'b0;
        end else begin
            // tag stages: entry 0 trails the issue register by one cycle
            tag_p[0] <= tag_in;
            for (int i = 1; i < TREE_LAT; i++) tag_p[i] <= tag_p[i-1];
            // response stage: a missing tree result still returns, with zero data
            rsp_valid <= tag_p[TREE_LAT-1].valid;
            if (tag_p[TREE_LAT-1].valid) begin
                rsp_id   <= tag_p[TREE_LAT-1].id[ID_W-1:0];
                rsp_last <= tag_p[TREE_LAT-1].last;
                rsp_data <= tree_out_valid ? tree_out_data : '0;
            end
            if (tag_p[TREE_LAT-1].valid != tree_out_valid) err_tag <= 1'b1;
        end
    end
endmodule

// File: rtl/sum8_arbiter.sv
// Round-robin/packet-lock scheduler sharing one sum_8 adder tree across lanes.
// Optional per-lane beat and stall counters: define SUM8_ARB_PERF_EN.
module sum8_arbiter
    import sum8_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int TREE_LAT = TREE_LAT_SUM8,
    parameter int ID_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    sum8_arbiter_if.slave        bus
`ifdef SUM8_ARB_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0] perf_beats,
    output logic [15:0]           perf_stall
`endif
);
    arb_state_e        state_q;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   owner_q;
    logic [ID_W-1:0]   grant_id;
    logic              grant_vld;
    logic [BEAT_W-1:0] lane_data [NUM_REQ];

    logic              issue_vld_p0;
    logic [ID_W-1:0]   issue_id_p0;
    logic              issue_last_p0;
    logic [BEAT_W-1:0] issue_data_p0;
    tag_t              issue_tag_p0;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
        return (int'(id) == NUM_REQ - 1) ? '0 : id + ID_W'(1);
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) lane_data[k] = bus.req_data[k*BEAT_W +: BEAT_W];
    end

    // Scan downward so the lane closest to ptr (lowest offset) wins last.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        idx       = 0;
        cand      = '0;
        grant_id  = ptr_q;
        grant_vld = 1'b0;
        if (state_q == ST_LOCK) begin
            grant_id  = owner_q;
            grant_vld = bus.req_valid[owner_q];
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                idx = int'(ptr_q) + i;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                cand = ID_W'(idx);
                if (bus.req_valid[cand]) begin
                    grant_id  = cand;
                    grant_vld = 1'b1;
                end
            end
        end
        if (!rst) grant_vld = 1'b0;
    end

    assign bus.req_ready = grant_vld ? (NUM_REQ'(1) << grant_id) : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
        end else if (grant_vld) begin
            if (bus.req_last[grant_id]) begin
                state_q <= ST_IDLE;
                ptr_q   <= wrap_inc(grant_id);
            end else begin
                state_q <= ST_LOCK;
                owner_q <= grant_id;
            end
        end
    end

    // issue stage: data and tag enter the tree and tag pipe together
    always_ff @(posedge clk) begin
        if (!rst) begin
            issue_vld_p0  <= 1'b0;
            issue_id_p0   <= '0;
            issue_last_p0 <= 1'b0;
            issue_data_p0 <= '0;
        end else begin
            issue_vld_p0 <= grant_vld;
            if (grant_vld) begin
                issue_id_p0   <= grant_id;
                issue_last_p0 <= bus.req_last[grant_id];
                issue_data_p0 <= lane_data[grant_id];
            end
        end
    end

    assign bus.tree_in_valid = issue_vld_p0;
    assign bus.tree_in_data  = issue_data_p0;
    assign issue_tag_p0      = '{valid: issue_vld_p0, id: TAG_ID_W'(issue_id_p0), last: issue_last_p0};

    sum8_tag_pipe #(
        .TREE_LAT (TREE_LAT),
        .ID_W     (ID_W)
    ) u_tag_pipe (
        .clk            (clk),
        .rst            (rst),
        .tag_in         (issue_tag_p0),
        .tree_out_valid (bus.tree_out_valid),
        .tree_out_data  (bus.tree_out_data),
        .rsp_valid      (bus.rsp_valid),
        .rsp_id         (bus.rsp_id),
        .rsp_data       (bus.rsp_data),
        .rsp_last       (bus.rsp_last),
        .err_tag        (bus.err_tag)
    );

`ifdef SUM8_ARB_PERF_EN
    logic [15:0] beats_q [NUM_REQ];
    logic [15:0] stall_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_REQ; k++) beats_q[k] <= '0;
            stall_q <= '0;
        end else begin
            if (grant_vld) beats_q[grant_id] <= sat_inc16(beats_q[grant_id]);
            if (|bus.req_valid && !grant_vld) stall_q <= sat_inc16(stall_q);
        end
    end

    always_comb begin
        perf_beats = '0;
        for (int k = 0; k < NUM_REQ; k++) perf_beats[k*16 +: 16] = beats_q[k];
    end
    assign perf_stall = stall_q;
`endif
endmodule

// File: tb/tb_sum8_arbiter.sv
// Directed bench for sum8_arbiter with a behavioural sum_8 stub (FP32 sum, ReLU, 4-cycle latency).
// Covers reset, single beat, round-robin, packet lock, owner gap, tag mismatch and mid-packet reset.
module tb_sum8_arbiter;
    import sum8_arbiter_pkg::*;

    localparam int NUM_REQ  = 4;
    localparam int TREE_LAT = 4;
    localparam int ID_W     = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic inject = 1'b0;
    logic drop = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] cyc_cnt = '0;

    always #5 clk = ~clk;

    sum8_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

`ifdef SUM8_ARB_PERF_EN
    logic [NUM_REQ*16-1:0] perf_beats;
    logic [15:0]           perf_stall;
`endif

    sum8_arbiter #(.NUM_REQ(NUM_REQ), .TREE_LAT(TREE_LAT), .ID_W(ID_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus)
`ifdef SUM8_ARB_PERF_EN
        ,
        .perf_beats (perf_beats),
        .perf_stall (perf_stall)
`endif
    );

    function automatic real fp2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2fp(input real v);
        real m;
        int  e;
        if (v <= 0.0) return 32'd0;
        m = v;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        return {1'b0, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
    endfunction

    function automatic logic [31:0] sum8(input logic [255:0] d);
        real acc;
        acc = 0.0;
        for (int j = 0; j < 8; j++) acc = acc + fp2r(d[32*j +: 32]);
        return r2fp(acc);
    endfunction

    logic        stub_v [TREE_LAT];
    logic [31:0] stub_d [TREE_LAT];

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 32'd1;
        if (!rst) begin
            for (int i = 0; i < TREE_LAT; i++) begin
                stub_v[i] <= 1'b0;
                stub_d[i] <= 32'd0;
            end
        end else begin
            stub_v[0] <= bus.tree_in_valid;
            stub_d[0] <= sum8(bus.tree_in_data);
            for (int i = 1; i < TREE_LAT; i++) begin
                stub_v[i] <= stub_v[i-1];
                stub_d[i] <= stub_d[i-1];
            end
        end
    end

    assign bus.tree_out_valid = (stub_v[TREE_LAT-1] & ~drop) | inject;
    assign bus.tree_out_data  = stub_d[TREE_LAT-1];

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
        logic            last;
        logic [31:0]     cyc;
    } rsp_t;
    rsp_t rq [$];

    always @(negedge clk) begin
        if (bus.rsp_valid) rq.push_back('{id: bus.rsp_id, data: bus.rsp_data, last: bus.rsp_last, cyc: cyc_cnt});
    end

    logic [31:0] opv  [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0] sumv [4] = '{32'h41000000, 32'h41800000, 32'h41C00000, 32'h42000000};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_lane(input int k, input logic v, input logic l, input logic [31:0] op);
        bus.req_valid[k]           = v;
        bus.req_last[k]            = l;
        bus.req_data[k*256 +: 256] = {8{op}};
    endtask

    task automatic idle_all();
        bus.req_valid = '0;
        bus.req_last  = '0;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b0;
        idle_all();
        next_cycle();
        rst = 1'b1;
        rq.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        next_cycle();
        next_cycle();
        sample();
        chk("reset_ready",   64'(bus.req_ready), 64'(0));
        chk("reset_tvalid",  64'(bus.tree_in_valid), 64'(0));
        chk("reset_tdata",   64'(|bus.tree_in_data), 64'(0));
        chk("reset_rvalid",  64'(bus.rsp_valid), 64'(0));
        chk("reset_rid",     64'(bus.rsp_id), 64'(0));
        chk("reset_rdata",   64'(bus.rsp_data), 64'(0));
        chk("reset_rlast",   64'(bus.rsp_last), 64'(0));
        chk("reset_err",     64'(bus.err_tag), 64'(0));
        next_cycle();
        rst = 1'b1;

        // single beat from lane 2, all operands 1.0
        set_lane(2, 1'b1, 1'b1, 32'h3F800000);
        sample();
        chk("single_ready", 64'(bus.req_ready), 64'(4'b0100));
        next_cycle();
        idle_all();
        sample();
        chk("single_tvalid", 64'(bus.tree_in_valid), 64'(1));
        chk("single_tdata", 64'(bus.tree_in_data === {8{32'h3F800000}}), 64'(1));
        repeat (4) next_cycle();
        sample();
        chk("single_early", 64'(bus.rsp_valid), 64'(0));
        next_cycle();
        sample();
        chk("single_rvalid", 64'(bus.rsp_valid), 64'(1));
        chk("single_rid",    64'(bus.rsp_id), 64'(2));
        chk("single_rdata",  64'(bus.rsp_data), 64'h41000000);
        chk("single_rlast",  64'(bus.rsp_last), 64'(1));
        chk("single_err",    64'(bus.err_tag), 64'(0));

        // round-robin with all lanes requesting single-beat packets
        do_reset();
        for (int k = 0; k < 4; k++) set_lane(k, 1'b1, 1'b1, opv[k]);
        for (int i = 0; i < 8; i++) begin
            sample();
            chk($sformatf("rr_ready%0d", i), 64'(bus.req_ready), 64'(4'b0001 << (i % 4)));
            next_cycle();
        end
        idle_all();
        repeat (7) next_cycle();
        sample();
        chk("rr_count", 64'(rq.size()), 64'(8));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rr_id%0d", i),   64'(rq[i].id), 64'(i % 4));
            chk($sformatf("rr_data%0d", i), 64'(rq[i].data), 64'(sumv[i % 4]));
            chk($sformatf("rr_cyc%0d", i),  64'(rq[i].cyc - rq[0].cyc), 64'(i));
        end

        // packet lock: lane 1 owns three beats while lane 0 waits
        do_reset();
        set_lane(0, 1'b1, 1'b1, opv[0]);
        sample();
        chk("lock_pre_ready", 64'(bus.req_ready), 64'(4'b0001));
        next_cycle();
        idle_all();
        repeat (8) next_cycle();
        rq.delete();
        set_lane(0, 1'b1, 1'b1, opv[0]);
        set_lane(1, 1'b1, 1'b0, opv[1]);
        for (int b = 0; b < 4; b++) begin
            bus.req_last[1]  = (b == 2);
            bus.req_valid[1] = (b < 3);
            sample();
            chk($sformatf("lock_ready%0d", b), 64'(bus.req_ready), 64'((b < 3) ? 4'b0010 : 4'b0001));
            next_cycle();
        end
        idle_all();
        repeat (7) next_cycle();
        sample();
        chk("lock_count", 64'(rq.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lock_id%0d", i),   64'(rq[i].id), 64'((i < 3) ? 1 : 0));
            chk($sformatf("lock_last%0d", i), 64'(rq[i].last), 64'((i >= 2) ? 1 : 0));
        end
        chk("lock_data1", 64'(rq[0].data), 64'h41800000);
        chk("lock_data0", 64'(rq[3].data), 64'h41000000);

        // owner gap: lane 3 locked and idle for two cycles while lane 0 waits
        do_reset();
        set_lane(3, 1'b1, 1'b0, opv[3]);
        sample();
        chk("gap_ready_a", 64'(bus.req_ready), 64'(4'b1000));
        next_cycle();
        set_lane(3, 1'b0, 1'b0, opv[3]);
        set_lane(0, 1'b1, 1'b1, opv[0]);
        sample();
        chk("gap_ready_1", 64'(bus.req_ready), 64'(0));
        chk("gap_tvalid_a", 64'(bus.tree_in_valid), 64'(1));
        next_cycle();
        sample();
        chk("gap_ready_2", 64'(bus.req_ready), 64'(0));
        chk("gap_tvalid_1", 64'(bus.tree_in_valid), 64'(0));
        next_cycle();
        set_lane(3, 1'b1, 1'b1, opv[3]);
        sample();
        chk("gap_ready_b", 64'(bus.req_ready), 64'(4'b1000));
        chk("gap_tvalid_2", 64'(bus.tree_in_valid), 64'(0));
        next_cycle();
        set_lane(3, 1'b0, 1'b0, opv[3]);
        sample();
        chk("gap_ready_0", 64'(bus.req_ready), 64'(4'b0001));
        chk("gap_tvalid_b", 64'(bus.tree_in_valid), 64'(1));
`ifdef SUM8_ARB_PERF_EN
        chk("perf_stall",  64'(perf_stall), 64'(2));
        chk("perf_beats3", 64'(perf_beats[3*16 +: 16]), 64'(2));
        chk("perf_beats0", 64'(perf_beats[0 +: 16]), 64'(0));
`endif
        next_cycle();
        idle_all();
        repeat (7) next_cycle();
        sample();
        chk("gap_count", 64'(rq.size()), 64'(3));
        chk("gap_id0", 64'(rq[0].id), 64'(3));
        chk("gap_id1", 64'(rq[1].id), 64'(3));
        chk("gap_id2", 64'(rq[2].id), 64'(0));
        chk("gap_data", 64'(rq[0].data), 64'h42000000);

        // tag mismatch: stray tree result, then a missing one
        do_reset();
        inject = 1'b1;
        sample();
        chk("mm_err_pre", 64'(bus.err_tag), 64'(0));
        next_cycle();
        inject = 1'b0;
        sample();
        chk("mm_err_set", 64'(bus.err_tag), 64'(1));
        chk("mm_rvalid", 64'(bus.rsp_valid), 64'(0));
        repeat (3) next_cycle();
        sample();
        chk("mm_err_hold", 64'(bus.err_tag), 64'(1));
        chk("mm_no_rsp", 64'(rq.size()), 64'(0));
        drop = 1'b1;
        set_lane(0, 1'b1, 1'b1, opv[0]);
        next_cycle();
        idle_all();
        repeat (7) next_cycle();
        sample();
        drop = 1'b0;
        chk("drop_count", 64'(rq.size()), 64'(1));
        chk("drop_id", 64'(rq[0].id), 64'(0));
        chk("drop_data", 64'(rq[0].data), 64'(0));
        chk("drop_err", 64'(bus.err_tag), 64'(1));

        // reset mid-packet: lock, pointer and in-flight tags discarded
        do_reset();
        set_lane(3, 1'b1, 1'b1, opv[3]);
        sample();
        chk("mr_ready3", 64'(bus.req_ready), 64'(4'b1000));
        next_cycle();
        idle_all();
        set_lane(2, 1'b1, 1'b1, opv[2]);
        sample();
        chk("mr_ready2", 64'(bus.req_ready), 64'(4'b0100));
        next_cycle();
        idle_all();
        set_lane(0, 1'b1, 1'b0, opv[0]);
        sample();
        chk("mr_ready0", 64'(bus.req_ready), 64'(4'b0001));
        next_cycle();
        sample();
        next_cycle();
        rst = 1'b0;
        sample();
        chk("mr_ready_rst", 64'(bus.req_ready), 64'(0));
        next_cycle();
        rst = 1'b1;
        idle_all();
        rq.delete();
        sample();
        chk("mr_tvalid", 64'(bus.tree_in_valid), 64'(0));
        chk("mr_tdata",  64'(|bus.tree_in_data), 64'(0));
        chk("mr_rvalid", 64'(bus.rsp_valid), 64'(0));
        chk("mr_rid",    64'(bus.rsp_id), 64'(0));
        chk("mr_rdata",  64'(bus.rsp_data), 64'(0));
        chk("mr_rlast",  64'(bus.rsp_last), 64'(0));
        chk("mr_err",    64'(bus.err_tag), 64'(0));
        next_cycle();
        set_lane(2, 1'b1, 1'b1, opv[2]);
        set_lane(3, 1'b1, 1'b1, opv[3]);
        sample();
        chk("mr_regrant", 64'(bus.req_ready), 64'(4'b0100));
        next_cycle();
        idle_all();
        repeat (9) next_cycle();
        sample();
        chk("mr_count", 64'(rq.size()), 64'(1));
        chk("mr_id",    64'(rq[0].id), 64'(2));
        chk("mr_data",  64'(rq[0].data), 64'h41C00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
